// File: rtl/raster_pkg.sv
// Shared types and index constants for the circle rasteriser.
// Octant names read as (x offset, y offset) relative to the centre; N marks subtraction.
package raster_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      EMIT,
      STEP,
      DONE
   } state_e;

   typedef enum logic {
      MODE_OUTLINE = 1'b0,
      MODE_FILLED  = 1'b1
   } mode_e;

   localparam logic [2:0] OCT_OX_OY   = 3'd0;
   localparam logic [2:0] OCT_OY_OX   = 3'd1;
   localparam logic [2:0] OCT_NOX_OY  = 3'd2;
   localparam logic [2:0] OCT_NOY_OX  = 3'd3;
   localparam logic [2:0] OCT_NOX_NOY = 3'd4;
   localparam logic [2:0] OCT_NOY_NOX = 3'd5;
   localparam logic [2:0] OCT_OX_NOY  = 3'd6;
   localparam logic [2:0] OCT_OY_NOX  = 3'd7;

   // Filled spans: rows cy+oy, cy-oy (half-width ox), then cy+ox, cy-ox (half-width oy).
   localparam logic [2:0] SPAN_POS_OY = 3'd0;
   localparam logic [2:0] SPAN_NEG_OY = 3'd1;
   localparam logic [2:0] SPAN_POS_OX = 3'd2;
   localparam logic [2:0] SPAN_NEG_OX = 3'd3;

endpackage

// File: rtl/midpoint_stepper.sv
// Midpoint-circle state (ox, oy, decision term) for one octant walk.
// 'more' reports whether the iteration that a STEP would produce still has oy <= ox.
module midpoint_stepper #(
   parameter int DW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init,
   input  logic                 step,
   input  logic [DW-1:0]        diameter,
   output logic signed [DW+1:0] ox,
   output logic signed [DW+1:0] oy,
   output logic                 more
);
   localparam int CW = DW + 2;

   logic signed [CW-1:0] ox_q, ox_d;
   logic signed [CW-1:0] oy_q, oy_d;
   logic signed [CW-1:0] crit_q, crit_d;
   logic signed [CW-1:0] radius, oy_inc, ox_dec, ox_nxt;
   logic                 crit_le0;

   // ox is signed so that r=0 steps to ox=-1 and terminates after one iteration.
   always_comb begin
      radius   = CW'(diameter >> 1);
      oy_inc   = oy_q + CW'(1);
      ox_dec   = ox_q - CW'(1);
      crit_le0 = crit_q[CW-1] || (crit_q == '0);
      ox_nxt   = crit_le0 ? ox_q : ox_dec;
      more     = (oy_inc <= ox_nxt);

      ox_d   = ox_q;
      oy_d   = oy_q;
      crit_d = crit_q;
      if (init) begin
         ox_d   = radius;
         oy_d   = '0;
         crit_d = CW'(1) - radius;
      end else if (step) begin
         oy_d = oy_inc;
         ox_d = ox_nxt;
         if (crit_le0) begin
            crit_d = crit_q + (oy_inc <<< 1) + CW'(1);
         end else begin
            crit_d = crit_q + ((oy_inc - ox_dec) <<< 1) + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         ox_q   <= '0;
         oy_q   <= '0;
         crit_q <= '0;
      end else begin
         ox_q   <= ox_d;
         oy_q   <= oy_d;
         crit_q <= crit_d;
      end
   end

   assign ox = ox_q;
   assign oy = oy_q;

endmodule

// File: rtl/circle_raster_gen.sv
// Circle / filled-disc rasteriser feeding the VGA adapter, with clipping and backpressure.
// Output registers lag the generator by one cycle; a stalled visible pixel freezes everything.
module circle_raster_gen
   import raster_pkg::*;
#(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    colour,
   input  logic [XW-1:0] centre_x,
   input  logic [YW-1:0] centre_y,
   input  logic [DW-1:0] diameter,
   input  logic          mode,
   input  logic          start,
   input  logic          vga_ready,
   output logic          done,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [2:0]    vga_colour,
   output logic          vga_plot
);
   localparam int XCW = XW + 2;
   localparam int YCW = YW + 2;
   localparam int CW  = DW + 2;
   localparam logic signed [XCW-1:0] X_LIM = XCW'(SCREEN_W);
   localparam logic signed [YCW-1:0] Y_LIM = YCW'(SCREEN_H);

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [2:0]            idx_q, idx_d;
   logic signed [XCW-1:0] k_q, k_d;
   logic [2:0]            colour_q, colour_d;
   logic [XW-1:0]         cx_q, cx_d;
   logic [YW-1:0]         cy_q, cy_d;
   logic [DW-1:0]         diam_q, diam_d;
   logic                  plot_q, plot_d;
   logic                  done_q, done_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [2:0]            pix_colour_q, pix_colour_d;

   logic signed [CW-1:0]  ox, oy;
   logic                  more, init, step, stall;
   logic signed [XCW-1:0] cx_s, ox_x, oy_x, hw_x, cand_x;
   logic signed [YCW-1:0] cy_s, ox_y, oy_y, cand_y;
   logic                  onscreen, span_last, last_cand;

   midpoint_stepper #(.DW(DW)) u_stepper (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (init),
      .step     (step),
      .diameter (diam_q),
      .ox       (ox),
      .oy       (oy),
      .more     (more)
   );

   assign cx_s  = {2'b00, cx_q};
   assign cy_s  = {2'b00, cy_q};
   assign ox_x  = XCW'(ox);
   assign oy_x  = XCW'(oy);
   assign ox_y  = YCW'(ox);
   assign oy_y  = YCW'(oy);
   assign stall = plot_q && !vga_ready;

   // Current candidate: octant point in outline mode, k-th pixel of the current span when filled.
   always_comb begin
      hw_x      = (idx_q == SPAN_POS_OY || idx_q == SPAN_NEG_OY) ? ox_x : oy_x;
      span_last = (k_q == (hw_x <<< 1));
      cand_x    = cx_s;
      cand_y    = cy_s;
      last_cand = 1'b0;
      if (mode_q == MODE_OUTLINE) begin
         case (idx_q)
            OCT_OX_OY:   begin cand_x = cx_s + ox_x; cand_y = cy_s + oy_y; end
            OCT_OY_OX:   begin cand_x = cx_s + oy_x; cand_y = cy_s + ox_y; end
            OCT_NOX_OY:  begin cand_x = cx_s - ox_x; cand_y = cy_s + oy_y; end
            OCT_NOY_OX:  begin cand_x = cx_s - oy_x; cand_y = cy_s + ox_y; end
            OCT_NOX_NOY: begin cand_x = cx_s - ox_x; cand_y = cy_s - oy_y; end
            OCT_NOY_NOX: begin cand_x = cx_s - oy_x; cand_y = cy_s - ox_y; end
            OCT_OX_NOY:  begin cand_x = cx_s + ox_x; cand_y = cy_s - oy_y; end
            OCT_OY_NOX:  begin cand_x = cx_s + oy_x; cand_y = cy_s - ox_y; end
         endcase
         last_cand = (idx_q == OCT_OY_NOX);
      end else begin
         cand_x = cx_s - hw_x + k_q;
         case (idx_q)
            SPAN_POS_OY: cand_y = cy_s + oy_y;
            SPAN_NEG_OY: cand_y = cy_s - oy_y;
            SPAN_POS_OX: cand_y = cy_s + ox_y;
            SPAN_NEG_OX: cand_y = cy_s - ox_y;
            default:     cand_y = cy_s;
         endcase
         last_cand = (idx_q == SPAN_NEG_OX) && span_last;
      end
      onscreen = !cand_x[XCW-1] && (cand_x < X_LIM) && !cand_y[YCW-1] && (cand_y < Y_LIM);
   end

   // Next-state and registered-output logic; nothing advances while a visible pixel is refused.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      idx_d        = idx_q;
      k_d          = k_q;
      colour_d     = colour_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      diam_d       = diam_q;
      plot_d       = plot_q;
      done_d       = done_q;
      x_d          = x_q;
      y_d          = y_q;
      pix_colour_d = pix_colour_q;
      init         = 1'b0;
      step         = 1'b0;
      if (!stall) begin
         case (state_q)
            IDLE: begin
               plot_d = 1'b0;
               done_d = 1'b0;
               if (start) begin
                  colour_d = colour;
                  cx_d     = centre_x;
                  cy_d     = centre_y;
                  diam_d   = diameter;
                  mode_d   = mode_e'(mode);
                  state_d  = INIT;
               end
            end
            INIT: begin
               init    = 1'b1;
               plot_d  = 1'b0;
               idx_d   = '0;
               k_d     = '0;
               state_d = EMIT;
            end
            EMIT: begin
               plot_d = onscreen;
               if (onscreen) begin
                  x_d          = cand_x[XW-1:0];
                  y_d          = cand_y[YW-1:0];
                  pix_colour_d = colour_q;
               end
               if (last_cand) begin
                  idx_d   = '0;
                  k_d     = '0;
                  state_d = STEP;
               end else if (mode_q == MODE_OUTLINE || span_last) begin
                  idx_d = idx_q + 3'd1;
                  k_d   = '0;
               end else begin
                  k_d = k_q + XCW'(1);
               end
            end
            STEP: begin
               step    = 1'b1;
               plot_d  = 1'b0;
               state_d = more ? EMIT : DONE;
            end
            DONE: begin
               plot_d = 1'b0;
               done_d = start;
               if (!start) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q      <= IDLE;
         mode_q       <= MODE_OUTLINE;
         idx_q        <= '0;
         k_q          <= '0;
         colour_q     <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         diam_q       <= '0;
         plot_q       <= 1'b0;
         done_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         pix_colour_q <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         idx_q        <= idx_d;
         k_q          <= k_d;
         colour_q     <= colour_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         diam_q       <= diam_d;
         plot_q       <= plot_d;
         done_q       <= done_d;
         x_q          <= x_d;
         y_q          <= y_d;
         pix_colour_q <= pix_colour_d;
      end
   end

   assign done       = done_q;
   assign vga_plot   = plot_q;
   assign vga_x      = x_q;
   assign vga_y      = y_q;
   assign vga_colour = pix_colour_q;

endmodule

// File: tb/tb_circle_raster_gen.sv
// Bench for circle_raster_gen: per-cycle comparison against a plain-arithmetic candidate list.
// Each draw is modelled as a list of visible cycles (pixels and one blank step cycle per iteration).
module tb_circle_raster_gen;

   logic       clk;
   logic       rst_n;
   logic [2:0] colour;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] diameter;
   logic       mode;
   logic       start;
   logic       vga_ready;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   typedef struct {
      bit plot;
      int x;
      int y;
   } ev_t;

   ev_t evq[$];
   int  checks = 0;
   int  errors = 0;
   int  exp_colour;

   circle_raster_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .colour     (colour),
      .centre_x   (centre_x),
      .centre_y   (centre_y),
      .diameter   (diameter),
      .mode       (mode),
      .start      (start),
      .vga_ready  (vga_ready),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic pushCand(input int x, input int y);
      ev_t e;
      e.plot = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
      e.x    = x;
      e.y    = y;
      evq.push_back(e);
   endtask

   // Midpoint walk with ordinary integers; one blank entry per iteration stands for the step cycle.
   task automatic buildModel(input int cx, input int cy, input int d, input bit filled);
      int ox, oy, crit;
      int px[8];
      int py[8];
      int rows[4];
      int half[4];
      ev_t blank;
      evq.delete();
      ox = d / 2;
      oy = 0;
      crit = 1 - ox;
      blank.plot = 1'b0;
      blank.x = 0;
      blank.y = 0;
      do begin
         if (!filled) begin
            px = '{cx+ox, cx+oy, cx-ox, cx-oy, cx-ox, cx-oy, cx+ox, cx+oy};
            py = '{cy+oy, cy+ox, cy+oy, cy+ox, cy-oy, cy-ox, cy-oy, cy-ox};
            for (int i = 0; i < 8; i++) pushCand(px[i], py[i]);
         end else begin
            rows = '{cy+oy, cy-oy, cy+ox, cy-ox};
            half = '{ox, ox, oy, oy};
            for (int s = 0; s < 4; s++)
               for (int x = cx - half[s]; x <= cx + half[s]; x++) pushCand(x, rows[s]);
         end
         evq.push_back(blank);
         oy = oy + 1;
         if (crit <= 0) begin
            crit = crit + 2 * oy + 1;
         end else begin
            ox = ox - 1;
            crit = crit + 2 * (oy - ox) + 1;
         end
      end while (oy <= ox);
   endtask

   // policy 0: always ready; 1: random ready; 2: first visible pixel refused for 5 cycles
   task automatic applyStimulus(input int cx, input int cy, input int d, input bit filled,
                                input int col, input int policy,
                                output int done_cycle, output int plots_seen);
      int  p, n, stall_left;
      bit  finished;
      ev_t e;
      buildModel(cx, cy, d, filled);
      exp_colour = col;
      @(negedge clk);
      centre_x  = 8'(cx);
      centre_y  = 7'(cy);
      diameter  = 8'(d);
      mode      = filled;
      colour    = 3'(col);
      vga_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      p = 0;
      n = 0;
      stall_left = (policy == 2) ? 5 : 0;
      finished = 1'b0;
      plots_seen = 0;
      done_cycle = -1;
      while (!finished && n < 20000) begin
         @(negedge clk);
         if (n == 0) begin
            colour   = 3'($urandom);
            centre_x = 8'($urandom);
            centre_y = 7'($urandom);
            diameter = 8'($urandom);
            mode     = 1'($urandom);
         end
         if (n < 2) begin
            checkOutput("lead_plot", vga_plot, 0);
            checkOutput("lead_done", done, 0);
            vga_ready = 1'b1;
         end else if (p < evq.size()) begin
            e = evq[p];
            checkOutput("plot", vga_plot, e.plot);
            checkOutput("busy_done", done, 0);
            if (e.plot) begin
               checkOutput("vga_x", vga_x, e.x);
               checkOutput("vga_y", vga_y, e.y);
               checkOutput("vga_colour", vga_colour, exp_colour);
            end
            case (policy)
               1:       vga_ready = ($urandom_range(0, 3) != 0);
               2: begin
                  if (e.plot && stall_left > 0) begin
                     vga_ready = 1'b0;
                     stall_left--;
                  end else begin
                     vga_ready = 1'b1;
                  end
               end
               default: vga_ready = 1'b1;
            endcase
            if (vga_plot === 1'b1 && vga_ready) plots_seen++;
            if (!(e.plot && !vga_ready)) p++;
         end else begin
            checkOutput("done", done, 1);
            checkOutput("done_plot", vga_plot, 0);
            done_cycle = n;
            finished = 1'b1;
         end
         n++;
      end
      vga_ready = 1'b1;
      if (!finished) checkOutput("draw_timeout", done, 1);
   endtask

   task automatic finishHandshake(input int hold);
      repeat (hold) begin
         @(negedge clk);
         checkOutput("hold_done", done, 1);
         checkOutput("hold_plot", vga_plot, 0);
      end
      start = 1'b0;
      @(negedge clk);
      checkOutput("release_done", done, 0);
      @(negedge clk);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_plot", vga_plot, 0);
   endtask

   initial begin
      int dc, ps;
      rst_n     = 1'b1;
      start     = 1'b0;
      vga_ready = 1'b1;
      colour    = '0;
      centre_x  = '0;
      centre_y  = '0;
      diameter  = '0;
      mode      = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_plot", vga_plot, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_x", vga_x, 0);
      checkOutput("reset_y", vga_y, 0);
      checkOutput("reset_colour", vga_colour, 0);
      rst_n = 1'b0;
      @(negedge clk);

      $display("[TB] outline d=0 at centre");
      applyStimulus(80, 60, 0, 1'b0, 5, 0, dc, ps);
      checkOutput("d0_done_cycle", dc, 11);
      checkOutput("d0_plots", ps, 8);
      finishHandshake(3);

      $display("[TB] outline d=2");
      applyStimulus(80, 60, 2, 1'b0, 3, 0, dc, ps);
      checkOutput("d2_done_cycle", dc, 20);
      checkOutput("d2_plots", ps, 16);
      finishHandshake(1);

      $display("[TB] filled d=2");
      applyStimulus(80, 60, 2, 1'b1, 6, 0, dc, ps);
      checkOutput("fill_done_cycle", dc, 24);
      checkOutput("fill_plots", ps, 20);
      finishHandshake(1);

      $display("[TB] clipped outline at origin");
      applyStimulus(0, 0, 2, 1'b0, 7, 0, dc, ps);
      checkOutput("clip_done_cycle", dc, 20);
      checkOutput("clip_plots", ps, 6);
      finishHandshake(1);

      $display("[TB] backpressure on first pixel");
      applyStimulus(80, 60, 2, 1'b0, 2, 2, dc, ps);
      checkOutput("stall_done_cycle", dc, 25);
      checkOutput("stall_plots", ps, 16);
      finishHandshake(2);

      $display("[TB] randomized draws");
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 30),
                       1'($urandom), $urandom_range(0, 7), 1, dc, ps);
         finishHandshake(1);
      end

      $display("[TB] reset during drawing");
      @(negedge clk);
      centre_x = 8'd80;
      centre_y = 7'd60;
      diameter = 8'd20;
      mode     = 1'b0;
      colour   = 3'd4;
      start    = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("pre_reset_plot", vga_plot, 1);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("abort_plot", vga_plot, 0);
      checkOutput("abort_done", done, 0);
      rst_n = 1'b0;
      repeat (20) begin
         @(negedge clk);
         checkOutput("post_abort_plot", vga_plot, 0);
         checkOutput("post_abort_done", done, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/circle_raster_gen.md
Name: circle_raster_gen

Overview:
- Parametrised successor to the lab circle drawers: rasterises a circle at (centre_x, centre_y) with a given diameter onto a SCREEN_W x SCREEN_H VGA framebuffer.
- Adds three things the earlier drawers lack: a filled-disc mode, clipping of off-screen pixels, and backpressure from the VGA writer.
- Sits between the top-level task controller (start/done handshake) and the VGA adapter port (vga_x/vga_y/vga_colour/vga_plot).

Parameters:
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- XW, 8, width of centre_x and vga_x.
- YW, 7, width of centre_y and vga_y.
- DW, 8, width of diameter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Despite the _n suffix, it is active-high and synchronous.
- colour  input  3  pixel colour.
- centre_x  input  XW  centre column.
- centre_y  input  YW  centre row.
- diameter  input  DW  circle diameter.
- mode  input  1  0 = outline, 1 = filled.
- start  input  1  level request.
- vga_ready  input  1  VGA writer can accept the current pixel.
- done  output  1  drawing complete.
- vga_x  output  XW  pixel column.
- vga_y  output  YW  pixel row.
- vga_colour  output  3  pixel colour.
- vga_plot  output  1  pixel valid.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port rst_n, asserted when 1).
- Reset: sampled on the rising edge of clk. All outputs go to 0 and the state goes to IDLE. A reset mid-drawing aborts the drawing immediately; no further vga_plot is issued.
- States: IDLE, INIT, EMIT, STEP, DONE.
- IDLE:
  - Waits for start=1.
  - On the edge where start=1 is sampled, latches colour, centre, diameter and mode, then goes to INIT.
  - Input changes after that edge are ignored.
- INIT (1 cycle):
  - r = diameter>>1 (floor).
  - ox = r, oy = 0.
  - crit = 1 - r, signed, DW+2 bits.
- EMIT produces one candidate pixel per advancing cycle.
  - Outline mode: 8 candidates per iteration, in this fixed order: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+ox,cy-oy), (cx+oy,cy-ox).
  - Filled mode: 4 spans per iteration, in order: row cy+oy over x=cx-ox..cx+ox; row cy-oy over the same x range; row cy+ox over x=cx-oy..cx+oy; row cy-ox over the same x range.
  - Filled spans are scanned with ascending x.
  - Duplicate pixels are emitted as-is. They are not deduplicated.
- Coordinate arithmetic is signed, XW+2 and YW+2 bits wide.
- Clipping:
  - A candidate with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H is clipped.
  - A clipped candidate still occupies one cycle, with vga_plot=0.
- On-screen candidates: vga_plot=1, with vga_x/vga_y/vga_colour driven from registers.
- Backpressure:
  - While vga_plot=1 and vga_ready=0, all outputs and the internal state hold.
  - A pixel counts as consumed on the edge where vga_plot=1 and vga_ready=1.
  - Clipped cycles ignore vga_ready.
- STEP (1 cycle, after the last candidate of an iteration):
  - oy += 1.
  - If crit <= 0: crit += 2*oy+1. Otherwise: ox -= 1, then crit += 2*(oy-ox)+1. Both updates use the new values.
  - If oy <= ox, go to EMIT. Otherwise go to DONE.
- DONE:
  - done=1 and vga_plot=0.
  - Stays in DONE while start=1.
  - When start=0 is sampled, done clears and the state returns to IDLE.
- Latency: the first candidate appears 2 cycles after the start edge (IDLE->INIT->EMIT).
- diameter 0 or 1 gives r=0: a single iteration with every candidate at the centre.

Decomposition:
- raster_pkg holds:
  - state enum (IDLE/INIT/EMIT/STEP/DONE);
  - mode enum (MODE_OUTLINE/MODE_FILLED);
  - octant-index localparams 0..7;
  - span-index localparams 0..3.
- One sub-module, midpoint_stepper. It holds ox/oy/crit, implements INIT and STEP, and flags end of the iteration sequence.

Test Plan:
- Outline, centre (80,60), diameter 0:
  - 8 plots, all at (80,60), vga_colour = colour.
  - done=1 at cycle 2+8+1 after the start edge with vga_ready=1.
- Outline, centre (80,60), diameter 2:
  - 16 plots in 2 iterations. The first is (81,60); the 9th is (81,61).
  - The plotted set is exactly {(81,60),(80,61),(79,60),(80,59),(81,61),(79,61),(79,59),(81,59)}.
- Filled, centre (80,60), diameter 2:
  - 20 plots.
  - Iteration 1: row 60 x=79..81 twice, then (80,61), then (80,59).
  - Iteration 2: rows 61,59,61,59 each x=79..81.
- Clipping, outline, centre (0,0), diameter 2:
  - 16 candidate cycles, of which 6 have vga_plot=1: (1,0),(0,1),(0,1),(1,0),(1,1),(1,1).
  - No negative coordinate is ever plotted.
- Backpressure: drive vga_ready=0 for 5 cycles on the first plot.
  - vga_x/vga_y stay stable throughout.
  - Plot sequence is identical to the unstalled run; done is delayed by exactly 5 cycles.
- Reset and handshake:
  - Assert rst_n=1 mid-EMIT: next cycle vga_plot=0 and done=0, with no further plots.
  - After done, holding start=1 keeps done=1; dropping start returns the block to IDLE.
